// File: rtl/ceespu_pc_unit_pkg.sv
// Shared types and default parameters for the ceespu program-counter unit.
// Purely declarative: no logic, no latency, no flow control.
package ceespu_pkg;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    ISR = 1'b1
  } pc_state_t;

  localparam int DEF_ADDR_W       = 14;
  localparam int DEF_RESET_VECTOR = 0;
  localparam int DEF_INT_VECTOR   = 1;
  localparam int DEF_RAS_DEPTH    = 4;

endpackage

// File: rtl/ceespu_pc_unit_if.sv
// Redirect/fetch-address bundle between decode/execute and the PC unit.
// Master drives the redirect requests, slave returns the registered PC and status.
interface ceespu_pc_unit_if
  import ceespu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              I_stall;
  logic              I_branch;
  logic [ADDR_W-1:0] I_branchAddress;
  logic              I_call;
  logic [ADDR_W-1:0] I_linkAddress;
  logic              I_ret;
  logic              I_irq;
  logic              I_reti;

  logic [ADDR_W-1:0] O_PC;
  logic              O_irqAck;
  logic              O_inIsr;
  logic              O_rasEmpty;
  logic              O_rasErr;

  modport master (
    output I_stall, I_branch, I_branchAddress, I_call, I_linkAddress,
           I_ret, I_irq, I_reti,
    input  O_PC, O_irqAck, O_inIsr, O_rasEmpty, O_rasErr
  );

  modport slave (
    input  I_stall, I_branch, I_branchAddress, I_call, I_linkAddress,
           I_ret, I_irq, I_reti,
    output O_PC, O_irqAck, O_inIsr, O_rasEmpty, O_rasErr
  );

endinterface

// File: rtl/ceespu_ras.sv
// Circular return-address stack; push/pop commit on the next edge, top is read from registers.
// Never stalls: push when full overwrites the oldest entry, pop when empty is ignored; both strobe an error.
module ceespu_ras
  import ceespu_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_dat_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              ovf_o,
  output logic              unf_o
);

  localparam int             PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign top_o   = mem_q[ptr_q];
  assign ovf_o   = push_i && full_o;
  assign unf_o   = pop_i && !push_i && empty_o;

  // The pointer wraps naturally; once full, a push lands on the oldest slot.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + 1'b1;
      if (!full_o) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage is deliberately left out of reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[ptr_d] <= push_dat_i;
    end
  end

endmodule

// File: rtl/ceespu_pc_unit.sv
// Fetch PC with branch/call/ret redirect, return-address stack and single-level interrupt entry/exit.
// One-cycle latency from request to O_PC; I_stall only blocks increment and interrupt entry.
module ceespu_pc_unit
  import ceespu_pkg::*;
#(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] INT_VECTOR   = ADDR_W'(DEF_INT_VECTOR),
  parameter int                RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input  logic           I_clk,
  input  logic           I_rst_n,
  ceespu_pc_unit_if.slave bus
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] seq_pc, flow_pc;
  pc_state_t         state_q, state_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic              irq_take, reti_take, call_take, ret_take;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty, ras_full, ras_ovf, ras_unf;

  assign seq_pc = pc_q + ONE;

  assign irq_take  = bus.I_irq && (state_q == RUN) && !bus.I_stall;
  assign reti_take = bus.I_reti && (state_q == ISR);
  // Stack side effects belong to the flow action, so they survive a concurrent interrupt entry.
  assign call_take = bus.I_call && !reti_take;
  assign ret_take  = bus.I_ret && !bus.I_call && !bus.I_branch && !reti_take;

  // Where the PC goes when neither interrupt entry nor exit applies; also the saved EPC.
  always_comb begin
    flow_pc = pc_q;
    if (bus.I_call || bus.I_branch) begin
      flow_pc = bus.I_branchAddress;
    end else if (bus.I_ret) begin
      flow_pc = ras_empty ? seq_pc : ras_top;
    end else if (!bus.I_stall) begin
      flow_pc = seq_pc;
    end
  end

  always_comb begin
    pc_d    = flow_pc;
    epc_d   = epc_q;
    state_d = state_q;
    ack_d   = 1'b0;
    if (irq_take) begin
      pc_d    = INT_VECTOR;
      epc_d   = flow_pc;
      state_d = ISR;
      ack_d   = 1'b1;
    end else if (reti_take) begin
      pc_d    = epc_q;
      state_d = RUN;
    end
  end

  assign err_d = err_q || ras_ovf || ras_unf;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= RESET_VECTOR;
      state_q <= RUN;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  ceespu_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (I_clk),
    .rst_n      (I_rst_n),
    .push_i     (call_take),
    .pop_i      (ret_take),
    .push_dat_i (bus.I_linkAddress),
    .top_o      (ras_top),
    .empty_o    (ras_empty),
    .full_o     (ras_full),
    .ovf_o      (ras_ovf),
    .unf_o      (ras_unf)
  );

  assign bus.O_PC       = pc_q;
  assign bus.O_irqAck   = ack_q;
  assign bus.O_inIsr    = (state_q == ISR);
  assign bus.O_rasEmpty = ras_empty;
  assign bus.O_rasErr   = err_q;

  a_ras_consistent: assert property (@(posedge I_clk) disable iff (!I_rst_n)
    !(ras_full && ras_empty));
  a_ack_in_isr: assert property (@(posedge I_clk) disable iff (!I_rst_n)
    ack_q |-> (state_q == ISR));

endmodule

// File: tb/tb_ceespu_pc_unit.sv
// Directed bench for ceespu_pc_unit: expectations are queued as stimulus is driven and checked after the edge.
module tb_ceespu_pc_unit;

  localparam int AW = 14;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          ack;
    logic          isr;
    logic          emp;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ceespu_pc_unit_if #(.ADDR_W(AW)) bus ();

  ceespu_pc_unit #(
    .ADDR_W       (AW),
    .RESET_VECTOR (14'h100),
    .INT_VECTOR   (14'h001),
    .RAS_DEPTH    (4)
  ) dut (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".pc"},    32'(bus.O_PC),       32'(e.pc));
    chk({tag, ".ack"},   32'(bus.O_irqAck),   32'(e.ack));
    chk({tag, ".isr"},   32'(bus.O_inIsr),    32'(e.isr));
    chk({tag, ".empty"}, 32'(bus.O_rasEmpty), 32'(e.emp));
    chk({tag, ".err"},   32'(bus.O_rasErr),   32'(e.err));
  endtask

  task automatic drive(input logic stall, input logic br, input logic call, input logic ret,
                       input logic irq, input logic reti,
                       input logic [AW-1:0] baddr, input logic [AW-1:0] link);
    bus.I_stall         = stall;
    bus.I_branch        = br;
    bus.I_call          = call;
    bus.I_ret           = ret;
    bus.I_irq           = irq;
    bus.I_reti          = reti;
    bus.I_branchAddress = baddr;
    bus.I_linkAddress   = link;
  endtask

  // Queue the expectation for the coming edge, then compare once the DUT has updated.
  task automatic cyc(input string tag, input logic [AW-1:0] pc, input logic ack,
                     input logic isr, input logic emp, input logic err);
    exp_t e;
    sb.push_back('{pc: pc, ack: ack, isr: isr, emp: emp, err: err});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_all(tag, e);
  endtask

  initial begin
    exp_t rst_e;
    rst_e = '{pc: 14'h100, ack: 1'b0, isr: 1'b0, emp: 1'b1, err: 1'b0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, '0, '0);
    #12;
    chk_all("reset", rst_e);
    #10 rst_n = 1'b1;

    // Sequential increment, then stall hold
    cyc("inc1", 14'h101, 0, 0, 1, 0);
    cyc("inc2", 14'h102, 0, 0, 1, 0);
    cyc("inc3", 14'h103, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, '0, '0);
    cyc("hold1", 14'h103, 0, 0, 1, 0);
    cyc("hold2", 14'h103, 0, 0, 1, 0);

    // Wrap at all-ones, branch while stalled
    drive(1, 1, 0, 0, 0, 0, 14'h3FFF, '0);
    cyc("br_top", 14'h3FFF, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, '0, '0);
    cyc("wrap", 14'h0000, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0, 0, 14'h200, '0);
    cyc("br_stall", 14'h200, 0, 0, 1, 0);

    // Five calls into a four-deep stack: the fifth overflows
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 0, 0, 0, 14'(14'h400 + i), 14'(14'h10 + i));
      cyc($sformatf("call%0d", i), 14'(14'h400 + i), 0, 0, 0, (i == 4));
    end
    // Four good returns, then an underflowing one that falls through to PC+1
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1, 0, 0, '0, '0);
      cyc($sformatf("ret%0d", i), 14'(14'h14 - i), 0, 0, (i == 3), 1);
    end
    cyc("ret_unf", 14'h12, 0, 0, 1, 1);

    // Call beats a simultaneous ret; the ret pops nothing
    drive(1, 0, 1, 1, 0, 0, 14'h60, 14'h33);
    cyc("call_ret", 14'h60, 0, 0, 0, 1);
    drive(1, 0, 0, 1, 0, 0, '0, '0);
    cyc("ret_after", 14'h33, 0, 0, 1, 1);

    // Interrupt entry with a concurrent branch saves the branch target
    drive(1, 1, 0, 0, 0, 0, 14'h50, '0);
    cyc("br50", 14'h50, 0, 0, 1, 1);
    drive(0, 1, 0, 0, 1, 0, 14'h80, '0);
    cyc("irq_entry", 14'h001, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 1, 0, '0, '0);
    cyc("isr_run", 14'h002, 0, 1, 1, 1);
    drive(0, 0, 0, 0, 1, 1, '0, '0);
    cyc("reti1", 14'h080, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1, 0, '0, '0);
    cyc("reenter", 14'h001, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 1, '0, '0);
    cyc("reti2", 14'h081, 0, 0, 1, 1);

    // Stall blocks entry; entry follows as soon as the stall drops
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 1, 0, '0, '0);
      cyc($sformatf("irq_stall%0d", i), 14'h081, 0, 0, 1, 1);
    end
    drive(0, 0, 0, 0, 1, 0, '0, '0);
    cyc("irq_late", 14'h001, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 1, '0, '0);
    cyc("reti3", 14'h082, 0, 0, 1, 1);
    cyc("reti_run", 14'h083, 0, 0, 1, 1);

    // Two stack entries, enter ISR, then reset asynchronously mid-cycle
    drive(1, 0, 1, 0, 0, 0, 14'h90, 14'h20);
    cyc("callA", 14'h090, 0, 0, 0, 1);
    drive(1, 0, 1, 0, 0, 0, 14'h91, 14'h21);
    cyc("callB", 14'h091, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, '0, '0);
    cyc("irq_ras", 14'h001, 1, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", rst_e);
    #2 rst_n = 1'b1;
    cyc("post_rst", 14'h101, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
